// File: rtl/flag_pkg.sv
// Shared constants for the MCU status flag bank: flag bit positions and default sizes.
package flag_pkg;
  localparam int FLAG_C       = 0;
  localparam int FLAG_Z       = 1;
  localparam int FLAG_WIDTH   = 2;
  localparam int SHADOW_DEPTH = 4;
endpackage : flag_pkg

// File: rtl/flag_shadow_stack.sv
// LIFO shadow stack for interrupt save/restore of the flags, with sticky overflow/underflow.
// One-cycle push/pop, no backpressure: rejected operations only raise ovf/unf.
module flag_shadow_stack
  import flag_pkg::*;
#(
  parameter int WIDTH = FLAG_WIDTH,
  parameter int DEPTH = SHADOW_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             save,
  input  logic             restore,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_vld;
  logic             ovf_evt;
  logic             unf_evt;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Restore takes precedence over save, so a simultaneous save is dropped silently.
  assign pop_vld  = restore && !empty;
  assign push_vld = save && !restore && !full;
  assign ovf_evt  = save && !restore && full;
  assign unf_evt  = restore && empty;

  assign pop_dat = mem[AW'(count - CW'(1))];

  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem[AW'(count)] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (pop_vld) begin
        count <= count - CW'(1);
      end else if (push_vld) begin
        count <= count + CW'(1);
      end
      // A new error in the same cycle as err_clr leaves the bit set.
      if (ovf_evt) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
      if (unf_evt) begin
        unf <= 1'b1;
      end else if (err_clr) begin
        unf <= 1'b0;
      end
    end
  end

endmodule : flag_shadow_stack

// File: rtl/flag_reg_bank.sv
// Flag register bank: per-bit clear > set > load priority, with a shadow stack for nested interrupts.
// One-cycle update latency; no backpressure, rejected save/restore are flagged via ovf/unf.
module flag_reg_bank
  import flag_pkg::*;
#(
  parameter int WIDTH = FLAG_WIDTH,
  parameter int DEPTH = SHADOW_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] clr,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] ld,
  input  logic [WIDTH-1:0] din,
  input  logic             save,
  input  logic             restore,
  input  logic             err_clr,
  output logic [WIDTH-1:0] flags,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  logic             pop_vld;
  logic [WIDTH-1:0] pop_dat;
  logic [WIDTH-1:0] upd_flags;

  // The pre-update flags are pushed, so save+clr stores the old value and clears in one edge.
  flag_shadow_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .save     (save),
    .restore  (restore),
    .err_clr  (err_clr),
    .push_dat (flags),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .unf      (unf)
  );

  assign upd_flags = (((flags & ~ld) | (din & ld)) | set) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (pop_vld) begin
      flags <= pop_dat;
    end else begin
      flags <= upd_flags;
    end
  end

endmodule : flag_reg_bank

// File: tb/tb_flag_reg_bank.sv
// Bench for flag_reg_bank at WIDTH=2, DEPTH=2: directed vector table, async reset sequence, random vs. queue model.
module tb_flag_reg_bank;
  import flag_pkg::*;

  localparam int W  = 2;
  localparam int D  = 2;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  clr = '0, set = '0, ld = '0, din = '0;
  logic          save = 1'b0, restore = 1'b0, err_clr = 1'b0;
  logic [W-1:0]  flags;
  logic [CW-1:0] count;
  logic          full, empty, ovf, unf;

  flag_reg_bank #(.WIDTH(W), .DEPTH(D), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .set(set), .ld(ld), .din(din),
    .save(save), .restore(restore), .err_clr(err_clr),
    .flags(flags), .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [W-1:0] clr, set, ld, din;
    logic         save, restore, err_clr;
    logic [W-1:0] e_flags;
    int           e_count;
    logic         e_ovf, e_unf;
  } vec_t;

  vec_t vecs[24];

  // Reference model: live flags, a queue as the shadow stack, sticky error bits.
  logic [W-1:0] m_flags;
  logic [W-1:0] m_q[$];
  logic         m_ovf, m_unf;

  function automatic logic [W-1:0] bit_update(logic [W-1:0] f, logic [W-1:0] c,
                                              logic [W-1:0] s, logic [W-1:0] l, logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      if (c[i])      r[i] = 1'b0;
      else if (s[i]) r[i] = 1'b1;
      else if (l[i]) r[i] = d[i];
      else           r[i] = f[i];
    end
    return r;
  endfunction

  task automatic model_step();
    logic oe, ue;
    logic [W-1:0] nf;
    oe = 1'b0; ue = 1'b0;
    nf = bit_update(m_flags, clr, set, ld, din);
    if (restore) begin
      if (m_q.size() > 0) nf = m_q.pop_back();
      else ue = 1'b1;
    end else if (save) begin
      if (m_q.size() < D) m_q.push_back(m_flags);
      else oe = 1'b1;
    end
    m_flags = nf;
    m_ovf = oe ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
    m_unf = ue ? 1'b1 : (err_clr ? 1'b0 : m_unf);
  endtask

  task automatic model_reset();
    m_flags = '0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".flags"}, flags, m_flags);
    check({tag, ".count"}, count, m_q.size());
    check({tag, ".full"},  full,  m_q.size() == D);
    check({tag, ".empty"}, empty, m_q.size() == 0);
    check({tag, ".ovf"},   ovf,   m_ovf);
    check({tag, ".unf"},   unf,   m_unf);
  endtask

  task automatic idle_inputs();
    clr = '0; set = '0; ld = '0; din = '0; save = 1'b0; restore = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [W-1:0] c, s, l, d, input logic sv, rs, ec);
    @(negedge clk);
    clr = c; set = s; ld = l; din = d; save = sv; restore = rs; err_clr = ec;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        clr    set    ld     din    sv rs ec  flags  cnt ovf unf
    vecs[0]  = '{2'b01, 2'b11, 2'b10, 2'b00, 0, 0, 0, 2'b10, 0, 0, 0};
    vecs[1]  = '{2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b11, 0, 0, 0};
    vecs[2]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b00, 1, 0, 0};
    vecs[3]  = '{2'b00, 2'b11, 2'b00, 2'b00, 0, 1, 0, 2'b11, 0, 0, 0};
    vecs[4]  = '{2'b00, 2'b00, 2'b11, 2'b01, 0, 0, 0, 2'b01, 0, 0, 0};
    vecs[5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 1, 0, 0};
    vecs[6]  = '{2'b00, 2'b00, 2'b11, 2'b10, 0, 0, 0, 2'b10, 1, 0, 0};
    vecs[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b10, 2, 0, 0};
    vecs[8]  = '{2'b00, 2'b00, 2'b11, 2'b11, 1, 0, 0, 2'b11, 2, 1, 0};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b10, 1, 1, 0};
    vecs[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b01, 0, 1, 0};
    vecs[11] = '{2'b00, 2'b00, 2'b11, 2'b10, 0, 1, 0, 2'b10, 0, 1, 1};
    vecs[12] = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b10, 0, 0, 0};
    vecs[13] = '{2'b00, 2'b00, 2'b11, 2'b01, 0, 0, 0, 2'b01, 0, 0, 0};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 1, 0, 0};
    vecs[15] = '{2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b11, 1, 0, 0};
    vecs[16] = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b01, 0, 0, 0};
    vecs[17] = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b01, 0, 0, 1};
    vecs[18] = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 2'b01, 0, 0, 1};
    vecs[19] = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 0, 0, 0};
    vecs[20] = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 1, 0, 0};
    vecs[21] = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 2, 0, 0};
    vecs[22] = '{2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b01, 2, 1, 0};
    vecs[23] = '{2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01, 2, 0, 0};

    // Reset state
    do_reset();
    #1;
    check("rst.flags", flags, 0);
    check("rst.count", count, 0);
    check("rst.empty", empty, 1);
    check("rst.full",  full,  0);
    check("rst.ovf",   ovf,   0);
    check("rst.unf",   unf,   0);

    // Directed vector table
    for (int i = 0; i < 24; i++) begin
      vec_t v;
      string tag;
      v = vecs[i];
      tag = $sformatf("vec%0d", i);
      step(v.clr, v.set, v.ld, v.din, v.save, v.restore, v.err_clr);
      check({tag, ".flags"}, flags, v.e_flags);
      check({tag, ".flag_c"}, flags[FLAG_C], v.e_flags[FLAG_C]);
      check({tag, ".flag_z"}, flags[FLAG_Z], v.e_flags[FLAG_Z]);
      check({tag, ".count"}, count, v.e_count);
      check({tag, ".full"},  full,  v.e_count == D);
      check({tag, ".empty"}, empty, v.e_count == 0);
      check({tag, ".ovf"},   ovf,   v.e_ovf);
      check({tag, ".unf"},   unf,   v.e_unf);
    end

    // Asynchronous reset between edges with flags=11, count=1
    do_reset();
    step(2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 0);
    step(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    check("pre_arst.flags", flags, 2'b11);
    check("pre_arst.count", count, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.flags", flags, 0);
    check("arst.count", count, 0);
    check("arst.empty", empty, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    // Back-to-back push then pop returns the just-pushed value
    step(2'b00, 2'b00, 2'b11, 2'b10, 0, 0, 0);
    step(2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    step(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
    check("b2b.flags", flags, 2'b10);
    check("b2b.count", count, 0);

    // Randomized run against the model, with occasional mid-cycle resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] c, s, l, d;
      logic sv, rs, ec;
      c  = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      s  = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      l  = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      d  = W'($urandom);
      sv = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 2) == 0);
      ec = ($urandom_range(0, 7) == 0);
      step(c, s, l, d, sv, rs, ec);
      check_model($sformatf("rnd%0d", n));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_model($sformatf("rnd_arst%0d", n));
        #1 rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_flag_reg_bank
